envelope_follower: RTL

//  Per-band envelope detector placed directly downstream of each biquad band-pass in the vocoder filter bank.

---
 rtl/envelope_follower.sv | 113 +++++++++++
 1 files changed

// File: rtl/envelope_follower.sv
// Per-band envelope detector: rectify, asymmetric one-pole smoothing,
// decimated output stream for the carrier-band gain stage.
module envelope_follower #(
    parameter int unsigned SHIFT   = 20,
    parameter int unsigned ATTACK  = 1 << 19,
    parameter int unsigned RELEASE = 1 << 16,
    parameter int unsigned DECIM   = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [31:0] sample_in,
    output logic        ready_out,
    output logic [31:0] env_out,
    output logic        valid_out,
    output logic        drop_out
);

    typedef enum logic [1:0] {IDLE, ABS, MUL, UPD} state_t;

    localparam logic [31:0]        MAX_POS    = 32'h7fff_ffff;
    localparam logic signed [64:0] MAX_POS65  = 65'sh0_7fff_ffff;
    localparam logic [31:0]        ATT_C      = 32'(ATTACK);
    localparam logic [31:0]        REL_C      = 32'(RELEASE);
    localparam logic [15:0]        DECIM_LAST = 16'(DECIM - 1);

    state_t state_q, state_d;

    logic signed [31:0] x_q;
    logic        [31:0] a_d;
    logic signed [32:0] diff_q;
    logic        [31:0] coeff_q;
    logic signed [64:0] diff_x, coeff_x;
    logic signed [64:0] prod_d, prod_q;
    logic signed [64:0] prod_sh, env_x, sum_d;
    logic        [31:0] env_q, env_d;
    logic        [15:0] decim_cnt_q;

    assign ready_out = (state_q == IDLE) && !rst_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (valid_in) state_d = ABS;
            ABS:  state_d = MUL;
            MUL:  state_d = UPD;
            UPD:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -2^31 has no positive twin in 32 bits, so it saturates
    always_comb begin
        if (x_q == 32'sh8000_0000) a_d = MAX_POS;
        else if (x_q < 0)          a_d = -x_q;
        else                       a_d = x_q;
    end

    assign diff_x  = {{32{diff_q[32]}}, diff_q};
    assign coeff_x = {33'b0, coeff_q};
    assign prod_d  = diff_x * coeff_x;
    assign prod_sh = prod_q >>> SHIFT;
    assign env_x   = {33'b0, env_q};
    assign sum_d   = env_x + prod_sh;

    always_comb begin
        if (sum_d < 0)              env_d = '0;
        else if (sum_d > MAX_POS65) env_d = MAX_POS;
        else                        env_d = sum_d[31:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_q         <= '0;
            diff_q      <= '0;
            coeff_q     <= '0;
            prod_q      <= '0;
            env_q       <= '0;
            env_out     <= '0;
            valid_out   <= 1'b0;
            drop_out    <= 1'b0;
            decim_cnt_q <= '0;
        end else begin
            valid_out <= 1'b0;
            if (valid_in && !ready_out) drop_out <= 1'b1;
            unique case (state_q)
                IDLE: if (valid_in) x_q <= sample_in;
                ABS: begin
                    diff_q  <= {1'b0, a_d} - {1'b0, env_q};
                    coeff_q <= (a_d > env_q) ? ATT_C : REL_C;
                end
                MUL: prod_q <= prod_d;
                UPD: begin
                    env_q <= env_d;
                    if (decim_cnt_q == DECIM_LAST) begin
                        env_out     <= env_d;
                        valid_out   <= 1'b1;
                        decim_cnt_q <= '0;
                    end else begin
                        decim_cnt_q <= decim_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
